// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, FSM state encoding and colour constants
// for the VGA raster generator and its output stage.
package vga_timing_pkg;

    localparam int CLK_DIV_DEF     = 4;
    localparam int H_TOTAL_DEF     = 800;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_ACT_START_DEF = 144;
    localparam int H_ACT_END_DEF   = 783;
    localparam int V_TOTAL_DEF     = 525;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_ACT_START_DEF = 35;
    localparam int V_ACT_END_DEF   = 514;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_RUN   = 1'b1
    } vga_state_t;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

    // Inclusive range test on a 10-bit raster coordinate.
    function automatic logic in_range(
        input logic [9:0] x,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_out_if.sv
// Bundle between the raster generator, the colour logic
// and the VGA connector pins.
interface vga_timing_out_if;

    logic [11:0] rgb_in;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        pix_en;
    logic        frame_tick;
    logic        hSync;
    logic        vSync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        input  rgb_in,
        output hCount,
        output vCount,
        output bright,
        output pix_en,
        output frame_tick,
        output hSync,
        output vSync,
        output vga_r,
        output vga_g,
        output vga_b
    );

    modport slave (
        output rgb_in,
        input  hCount,
        input  vCount,
        input  bright,
        input  pix_en,
        input  frame_tick,
        input  hSync,
        input  vSync,
        input  vga_r,
        input  vga_g,
        input  vga_b
    );

endinterface

// File: rtl/vga_timing_out_pixel_clk_en.sv
// Pixel-rate enable: divides clk by CLK_DIV and pulses pix_en
// on the last system clock of every pixel period.
module pixel_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    // Free-running divider, wraps after CLK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    assign pix_en = (div_q == LAST);

endmodule

// File: rtl/vga_timing_out.sv
// 640x480@60 raster counters, blank-first-frame FSM and registered
// sync/colour pins. Optional macro VGA_BORDER_EN draws a white frame border.
module vga_timing_out
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_ACT_START = H_ACT_START_DEF,
    parameter int H_ACT_END   = H_ACT_END_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_ACT_START = V_ACT_START_DEF,
    parameter int V_ACT_END   = V_ACT_END_DEF
) (
    input logic             clk,
    input logic             rst,
    vga_timing_out_if.master bus
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] H_AS   = 10'(H_ACT_START);
    localparam logic [9:0] H_AE   = 10'(H_ACT_END);
    localparam logic [9:0] V_AS   = 10'(V_ACT_START);
    localparam logic [9:0] V_AE   = 10'(V_ACT_END);

    logic        pix_en;
    logic [9:0]  h_q;
    logic [9:0]  v_q;
    logic        h_wrap;
    logic        v_wrap;
    logic        bright;
    logic        frame_tick;
    logic        edge_px;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;
    vga_state_t  state_q;
    vga_state_t  state_d;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    // Raster position, stepped once per pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_q <= '0;
                v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 10'd1;
            end
        end
    end

    assign bright = in_range(h_q, H_AS, H_AE)
                 && in_range(v_q, V_AS, V_AE);

    assign frame_tick = pix_en && h_wrap && v_wrap;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold the pins dark until one full frame has gone by.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BLANK: if (frame_tick) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
        endcase
    end

`ifdef VGA_BORDER_EN
    assign edge_px = (h_q == H_AS) || (h_q == H_AE)
                  || (v_q == V_AS) || (v_q == V_AE);
`else
    assign edge_px = 1'b0;
`endif

    // Colour for the current position, before registering.
    always_comb begin
        rgb_d = BLACK;
        if (bright && state_q == S_RUN) begin
            rgb_d = edge_px ? WHITE : bus.rgb_in;
        end
    end

    // Register syncs and colour together so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= BLACK;
        end else if (pix_en) begin
            hs_q  <= (h_q >= H_SW);
            vs_q  <= (v_q >= V_SW);
            rgb_q <= rgb_d;
        end
    end

    assign bus.hCount     = h_q;
    assign bus.vCount     = v_q;
    assign bus.bright     = bright;
    assign bus.pix_en     = pix_en;
    assign bus.frame_tick = frame_tick;
    assign bus.hSync      = hs_q;
    assign bus.vSync      = vs_q;
    assign bus.vga_r      = rgb_q[11:8];
    assign bus.vga_g      = rgb_q[7:4];
    assign bus.vga_b      = rgb_q[3:0];

endmodule
